// File: rtl/dmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_bus_ctrl
//   Data-memory bus controller that sits directly after the load/store access
//   manager. It takes one word-aligned request from the MEM stage, runs it as
//   a single-beat cyc/ack bus transaction, and stalls the pipeline until the
//   transaction completes or times out. The raw 32-bit read word is returned
//   as cpu_rdata.
//
//   Parameters
//     TIMEOUT    max BUS-state cycles to wait for mem_ack (0 disables timeout)
//
//   Ports
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     cpu_req/we     MEM-stage request strobe and store/load select
//     cpu_addr       word address [31:2]
//     cpu_be         byte enables (0 = zero-byte access, no bus cycle)
//     cpu_wdata      byte-lane-replicated store data
//     cpu_rdata      raw read word, valid in DONE, held until next read/timeout
//     cpu_stall      pipeline freeze (combinational)
//     cpu_err        one-cycle bus-timeout pulse
//     mem_cyc/we     bus cycle active / bus write
//     mem_addr/be    bus word address / byte enables
//     mem_wdata      bus write data
//     mem_rdata      bus read data, taken together with mem_ack
//     mem_ack        bus completion, only looked at in BUS
// ---------------------------------------------------------------------------
module dmem_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [29:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        mem_cyc,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             mem_cyc_q,   mem_cyc_d;
  logic             mem_we_q,    mem_we_d;
  logic [29:0]      mem_addr_q,  mem_addr_d;
  logic [3:0]       mem_be_q,    mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic             cpu_err_q,   cpu_err_d;

  logic start_req;
  logic timeout_hit;

  assign start_req   = cpu_req & (|cpu_be);
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_cyc_d   = mem_cyc_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    // cpu_err is a pulse: it only survives the edge that raises it.
    cpu_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          mem_cyc_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_be_d    = cpu_be;
          mem_wdata_d = cpu_wdata;
          cnt_d       = '0;
          state_d     = S_BUS;
        end
      end
      S_BUS: begin
        // Ack is checked first so that an ack in the last allowed cycle wins.
        if (mem_ack) begin
          mem_cyc_d = 1'b0;
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else if (timeout_hit) begin
          mem_cyc_d   = 1'b0;
          cpu_rdata_d = '0;
          cpu_err_d   = 1'b1;
          state_d     = S_DONE;
        end else if (TO_EN) begin
          // Never wraps: the timeout fires at TIMEOUT-1 before reaching TIMEOUT.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_cyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_cyc_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_cyc_q   <= mem_cyc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  // Gated by rst_n so the stall drops during reset even if cpu_req is held.
  assign cpu_stall = rst_n & (((state_q == S_IDLE) & start_req) | (state_q == S_BUS));

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;
  assign mem_cyc   = mem_cyc_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
module tb_dmem_bus_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [29:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        mem_cyc, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  dmem_bus_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .mem_cyc(mem_cyc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what cpu_rdata must hold between transactions.
  logic [31:0] model_rdata = '0;

  // Observations collected by the transaction driver.
  int          obs_stall, obs_cyc, obs_err;
  logic        obs_err_after, obs_stall_after, obs_cyc_after;
  logic [31:0] obs_rdata;
  logic        obs_we;
  logic [29:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  bit          obs_stable, obs_done;

  // Transaction-level model: d = index of the BUS cycle carrying ack (<0: never).
  function automatic void model_txn(input logic we, input int d, input logic [31:0] rd,
                                    output int e_cyc, output int e_stall, output int e_err,
                                    output logic [31:0] e_rdata);
    bit to;
    to      = (d < 0) || (d >= T);
    e_cyc   = to ? T : d + 1;
    e_stall = e_cyc + 1;
    e_err   = to ? 1 : 0;
    e_rdata = to ? 32'h0 : (we ? model_rdata : rd);
  endfunction

  // Drives one request, answers the bus, records what it sees. No checking here.
  task automatic do_txn(input logic we, input logic [29:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input int d, input logic [31:0] rd,
                        input bit toggle);
    bit seen_stall;
    seen_stall = 0;
    obs_stall = 0; obs_cyc = 0; obs_err = 0; obs_stable = 1; obs_done = 0;
    obs_rdata = 'x; obs_we = 'x; obs_addr = 'x; obs_be = 'x; obs_wdata = 'x;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
    mem_ack = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (cpu_err) obs_err++;
      if (cpu_stall) begin obs_stall++; seen_stall = 1; end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_cyc) begin
        if (obs_cyc == 0) begin
          obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
        end else if (mem_we !== obs_we || mem_addr !== obs_addr || mem_be !== obs_be ||
                     mem_wdata !== obs_wdata) begin
          obs_stable = 0;
        end
        if (d >= 0 && obs_cyc == d) begin mem_ack = 1'b1; mem_rdata = rd; end
        obs_cyc++;
        if (toggle) begin
          cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 30'($urandom);
          cpu_be = 4'($urandom); cpu_wdata = $urandom;
        end
      end else if (seen_stall && !cpu_stall) begin
        obs_done = 1; obs_rdata = cpu_rdata; cpu_req = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
    @(negedge clk); #1;
    obs_err_after = cpu_err; obs_stall_after = cpu_stall; obs_cyc_after = mem_cyc;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    rst_n = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h3; cpu_be = 4'hF;
    cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_cyc, mem_we, mem_addr, mem_be, mem_wdata, cpu_rdata, cpu_err, cpu_stall} !== '0) begin
      errors++; $display("FAIL reset_outputs got cyc=%b stall=%b rdata=%h want all zero", mem_cyc, cpu_stall, cpu_rdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; cpu_req = 1'b0;
    rd = $urandom | 32'h1;
    do_txn(1'b0, 30'h123, 4'hF, '0, 1, rd, 0);
    model_rdata = rd;
    checks++;
    if (obs_rdata !== rd) begin errors++; $display("FAIL reset_pre_read got %h want %h", obs_rdata, rd); end
    // Abort a read in its first BUS cycle while ack is being presented.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h77; cpu_be = 4'hF;
    @(negedge clk); #1;
    checks++;
    if (mem_cyc !== 1'b1) begin errors++; $display("FAIL reset_midbus_setup got cyc=%b want 1", mem_cyc); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_cyc !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL reset_async_drop got cyc=%b stall=%b want 0 0", mem_cyc, cpu_stall);
    end
    @(posedge clk); #1;
    checks++;
    if ({mem_cyc, mem_we, mem_addr, mem_be, mem_wdata, cpu_rdata, cpu_err, cpu_stall} !== '0) begin
      errors++; $display("FAIL reset_held got cyc=%b stall=%b rdata=%h want all zero", mem_cyc, cpu_stall, cpu_rdata);
    end
    @(negedge clk); rst_n = 1'b1; cpu_req = 1'b0; mem_ack = 1'b0;
    model_rdata = '0;
    rd = $urandom | 32'h100;
    do_txn(1'b0, 30'h200, 4'h3, '0, 2, rd, 0);
    model_rdata = rd;
    checks++;
    if (obs_rdata !== rd || obs_stall != 4 || obs_err != 0) begin
      errors++; $display("FAIL reset_post_read got rdata=%h stall=%0d err=%0d want %h 4 0", obs_rdata, obs_stall, obs_err, rd);
    end
  endtask

  task automatic test_load;
    do_txn(1'b0, 30'h40, 4'hF, 32'h0, 3, 32'hDEADBEEF, 0);
    model_rdata = 32'hDEADBEEF;
    checks++;
    if (obs_addr !== 30'h40 || obs_we !== 1'b0 || obs_be !== 4'hF) begin
      errors++; $display("FAIL load_bus got addr=%h we=%b be=%h want 40 0 f", obs_addr, obs_we, obs_be);
    end
    checks++;
    if (obs_stall != 5 || obs_cyc != 4) begin
      errors++; $display("FAIL load_latency got stall=%0d cyc=%0d want 5 4", obs_stall, obs_cyc);
    end
    checks++;
    if (obs_rdata !== 32'hDEADBEEF || obs_err != 0 || !obs_done) begin
      errors++; $display("FAIL load_data got rdata=%h err=%0d done=%0d want deadbeef 0 1", obs_rdata, obs_err, obs_done);
    end
  endtask

  task automatic test_byte_store;
    do_txn(1'b1, 30'h1555, 4'b0100, 32'hABABABAB, 0, 32'h11111111, 1);
    checks++;
    if (obs_we !== 1'b1 || obs_be !== 4'b0100 || obs_wdata !== 32'hABABABAB || obs_addr !== 30'h1555) begin
      errors++; $display("FAIL store_bus got we=%b be=%b wdata=%h addr=%h", obs_we, obs_be, obs_wdata, obs_addr);
    end
    checks++;
    if (obs_stall != 2 || obs_cyc != 1) begin
      errors++; $display("FAIL store_latency got stall=%0d cyc=%0d want 2 1", obs_stall, obs_cyc);
    end
    checks++;
    if (obs_rdata !== model_rdata) begin
      errors++; $display("FAIL store_rdata got %h want %h", obs_rdata, model_rdata);
    end
    // A longer store with inputs churning during BUS: bus side must not move.
    do_txn(1'b1, 30'h2AA, 4'b1001, 32'h5A5A0F0F, 4, 32'h0, 1);
    checks++;
    if (!obs_stable || obs_wdata !== 32'h5A5A0F0F || obs_cyc != 5) begin
      errors++; $display("FAIL store_stable got stable=%0d wdata=%h cyc=%0d want 1 5a5a0f0f 5", obs_stable, obs_wdata, obs_cyc);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] rd;
    do_txn(1'b0, 30'h99, 4'hF, '0, -1, '0, 0);
    checks++;
    if (obs_cyc != T || obs_stall != T + 1) begin
      errors++; $display("FAIL timeout_len got cyc=%0d stall=%0d want %0d %0d", obs_cyc, obs_stall, T, T + 1);
    end
    checks++;
    if (obs_err != 1 || obs_err_after !== 1'b0) begin
      errors++; $display("FAIL timeout_err got pulses=%0d after=%b want 1 0", obs_err, obs_err_after);
    end
    checks++;
    if (obs_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata got %h want 0", obs_rdata); end
    model_rdata = '0;
    rd = $urandom | 32'h8000_0000;
    do_txn(1'b0, 30'h9A, 4'hF, '0, T - 1, rd, 0);
    model_rdata = rd;
    checks++;
    if (obs_err != 0 || obs_rdata !== rd || obs_cyc != T) begin
      errors++; $display("FAIL ack_last_cycle got err=%0d rdata=%h cyc=%0d want 0 %h %0d", obs_err, obs_rdata, obs_cyc, rd, T);
    end
  endtask

  task automatic test_zero_byte;
    int bad;
    bad = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = 30'h55; cpu_wdata = $urandom;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (cpu_stall !== 1'b0 || mem_cyc !== 1'b0) bad++;
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      cpu_we = 1'($urandom);
    end
    cpu_req = 1'b0; mem_ack = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL zero_byte got %0d active cycles want 0", bad); end
    checks++;
    if (cpu_rdata !== model_rdata) begin
      errors++; $display("FAIL zero_byte_rdata got %h want %h", cpu_rdata, model_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2, n, bad;
    bit bus, stl;
    logic [31:0] rd1, rdata_load, rdata_end;
    logic store_we;
    logic [29:0] store_addr;
    d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3);
    rd1 = $urandom; n = d1 + d2 + 6; bad = 0;
    rdata_load = 'x; rdata_end = 'x; store_we = 'x; store_addr = 'x;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h10; cpu_be = 4'hF; cpu_wdata = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == d1 + 2) begin cpu_we = 1'b1; cpu_addr = 30'h20; cpu_be = 4'b0011; cpu_wdata = 32'h1234_5678; end
      #1;
      bus = (i >= 1 && i <= d1 + 1) || (i >= d1 + 4 && i <= d1 + d2 + 4);
      stl = bus || i == 0 || i == d1 + 3;
      if (mem_cyc !== bus || cpu_stall !== stl) bad++;
      if (i == d1 + 2) rdata_load = cpu_rdata;
      if (i == d1 + 4) begin store_we = mem_we; store_addr = mem_addr; end
      if (i == n - 1) rdata_end = cpu_rdata;
      mem_rdata = $urandom;
      if (bus) begin
        mem_ack = (i == d1 + 1) || (i == d1 + d2 + 4);
        if (i == d1 + 1) mem_rdata = rd1;
      end else begin
        mem_ack = 1'($urandom);
      end
    end
    cpu_req = 1'b0; mem_ack = 1'b0;
    model_rdata = rd1;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_trace got %0d wrong cycles want 0 (d1=%0d d2=%0d)", bad, d1, d2); end
    checks++;
    if (rdata_load !== rd1 || rdata_end !== rd1) begin
      errors++; $display("FAIL b2b_rdata got %h/%h want %h", rdata_load, rdata_end, rd1);
    end
    checks++;
    if (store_we !== 1'b1 || store_addr !== 30'h20) begin
      errors++; $display("FAIL b2b_store got we=%b addr=%h want 1 20", store_we, store_addr);
    end
  endtask

  task automatic test_random;
    logic we; logic [29:0] addr; logic [3:0] be; logic [31:0] wd, rd, e_rdata;
    int d, e_cyc, e_stall, e_err;
    for (int k = 0; k < 24; k++) begin
      we = 1'($urandom); addr = 30'($urandom); be = 4'($urandom_range(1, 15));
      wd = $urandom; rd = $urandom; d = int'($urandom_range(0, 11)) - 1;
      model_txn(we, d, rd, e_cyc, e_stall, e_err, e_rdata);
      do_txn(we, addr, be, wd, d, rd, 1'($urandom));
      model_rdata = e_rdata;
      checks++;
      if (obs_we !== we || obs_addr !== addr || obs_be !== be || obs_wdata !== wd || !obs_stable) begin
        errors++; $display("FAIL rand%0d_bus got we=%b addr=%h be=%h wd=%h stable=%0d want %b %h %h %h 1", k, obs_we, obs_addr, obs_be, obs_wdata, obs_stable, we, addr, be, wd);
      end
      checks++;
      if (obs_cyc != e_cyc || obs_stall != e_stall || obs_err != e_err || obs_err_after !== 1'b0) begin
        errors++; $display("FAIL rand%0d_timing got cyc=%0d stall=%0d err=%0d want %0d %0d %0d (d=%0d)", k, obs_cyc, obs_stall, obs_err, e_cyc, e_stall, e_err, d);
      end
      checks++;
      if (obs_rdata !== e_rdata) begin
        errors++; $display("FAIL rand%0d_rdata got %h want %h", k, obs_rdata, e_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_byte_store();
    test_timeout();
    test_zero_byte();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
